// File: rtl/seven_seg_reader.sv
// seven_seg_reader
// Reads an active-low seven-segment pattern {A..G}, waits until it has been
// stable for STABLE_CYCLES clocks, then decodes it to a hex nibble and holds
// the result with Valid until the consumer acknowledges it. After an
// acknowledge the same pattern is never reported again until it changes.
//
// Optional feature, guarded by the macro SEVEN_SEG_READER_ERRCNT_EN:
//   adds the 8-bit output ErrCount, a saturating count of illegal patterns
//   accepted since reset.
module seven_seg_reader #(
  parameter int STABLE_CYCLES = 4  // legal range 1..15
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  input  logic       Ack,
  output logic       X3,
  output logic       X2,
  output logic       X1,
  output logic       X0,
  output logic       Valid,
  output logic       Error
`ifdef SEVEN_SEG_READER_ERRCNT_EN
  ,
  output logic [7:0] ErrCount
`endif
);

  // Acceptance threshold as a 4-bit constant matching the counter width.
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  // Segment pattern that is blank (all lines high = all segments off).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,   // counting stable samples
    ST_HOLD,   // result presented, waiting for Ack
    ST_REARM   // result consumed, waiting for the pattern to change
  } state_t;

  // Decode {A..G} to {legal, hex}. Anything outside the 16 legal glyphs
  // returns legal = 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'b0_0000;
    case (seg)
      7'b0000001: res = 5'b1_0000;
      7'b1001111: res = 5'b1_0001;
      7'b0010010: res = 5'b1_0010;
      7'b0000110: res = 5'b1_0011;
      7'b1001100: res = 5'b1_0100;
      7'b0100100: res = 5'b1_0101;
      7'b0100000: res = 5'b1_0110;
      7'b0001111: res = 5'b1_0111;
      7'b0000000: res = 5'b1_1000;
      7'b0000100: res = 5'b1_1001;
      7'b0001000: res = 5'b1_1010;
      7'b1100000: res = 5'b1_1011;
      7'b0110001: res = 5'b1_1100;
      7'b1000010: res = 5'b1_1101;
      7'b0110000: res = 5'b1_1110;
      7'b0111000: res = 5'b1_1111;
      default:    res = 5'b0_0000;
    endcase
    return res;
  endfunction

  logic [6:0] seg_bus;
  logic [6:0] seg_diff;
  logic       seg_change;

  logic [6:0] s_reg;
  logic [3:0] cnt_reg;
  logic [3:0] cnt_next;
  logic [3:0] cnt_step;

  state_t     state_reg;
  state_t     state_next;
  logic [6:0] p_reg;
  logic [6:0] p_next;
  logic [3:0] x_reg;
  logic [3:0] x_next;
  logic       valid_reg;
  logic       valid_next;
  logic       error_reg;
  logic       error_next;

  logic [4:0] dec_res;
  logic       dec_legal;
  logic [3:0] dec_value;

  assign seg_bus = {A, B, C, D, E, F, G};

  // Per-line difference between the incoming lines and the sample register;
  // any set bit means the sample is about to change.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_seg_diff
      assign seg_diff[gi] = seg_bus[gi] ^ s_reg[gi];
    end
  endgenerate

  assign seg_change = |seg_diff;

  // Counter increment saturating at the acceptance threshold.
  assign cnt_step = (cnt_reg >= STABLE) ? STABLE : (cnt_reg + 4'd1);

  // Decode always works on the registered sample.
  assign dec_res   = seg_decode(s_reg);
  assign dec_legal = dec_res[4];
  assign dec_value = dec_res[3:0];

  // Sample register and stability counter.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      s_reg   <= SEG_BLANK;
      cnt_reg <= 4'd0;
    end else begin
      s_reg   <= seg_bus;
      cnt_reg <= cnt_next;
    end
  end

  // FSM state and held-result registers.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_reg <= ST_IDLE;
      p_reg     <= SEG_BLANK;
      x_reg     <= 4'd0;
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      x_reg     <= x_next;
      valid_reg <= valid_next;
      error_reg <= error_next;
    end
  end

  // Next-state, counter and held-result logic.
  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    x_next     = x_reg;
    valid_next = valid_reg;
    error_next = error_reg;
    // A sample change restarts the count; otherwise count up.
    cnt_next   = seg_change ? 4'd0 : cnt_step;

    case (state_reg)
      ST_IDLE: begin
        // The count reaches the threshold on this edge: accept the pattern.
        if (!seg_change && (cnt_step == STABLE)) begin
          state_next = ST_HOLD;
          valid_next = 1'b1;
          p_next     = s_reg;
          if (dec_legal) begin
            x_next     = dec_value;
            error_next = 1'b0;
          end else begin
            x_next     = 4'd0;
            error_next = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // X is left as-is so the last value remains visible after Ack.
        if (Ack) begin
          state_next = ST_REARM;
          valid_next = 1'b0;
          error_next = 1'b0;
        end
      end
      ST_REARM: begin
        // Only a different pattern may start a new acceptance.
        if (s_reg != p_reg) begin
          state_next = ST_IDLE;
          cnt_next   = 4'd0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        valid_next = 1'b0;
        error_next = 1'b0;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign {X3, X2, X1, X0} = x_reg;
  assign Valid            = valid_reg;
  assign Error            = error_reg;

`ifdef SEVEN_SEG_READER_ERRCNT_EN
  logic [7:0] errcnt_reg;
  logic       err_accept;

  assign err_accept = (state_reg == ST_IDLE) && (state_next == ST_HOLD) && !dec_legal;

  // Saturating count of illegal acceptances; only reset clears it.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      errcnt_reg <= 8'd0;
    end else if (err_accept && (errcnt_reg != 8'hFF)) begin
      errcnt_reg <= errcnt_reg + 8'd1;
    end
  end

  assign ErrCount = errcnt_reg;
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: a table of glyphs with expected
// decode, plus hand-written sequences for restart, reset and Ack corners.
module tb_seven_seg_reader;

  localparam int N = 4;

  logic Clock;
  logic Resetn;
  logic A, B, C, D, E, F, G;
  logic Ack;
  logic X3, X2, X1, X0;
  logic Valid;
  logic Error;
`ifdef SEVEN_SEG_READER_ERRCNT_EN
  logic [7:0] ErrCount;
`endif

  seven_seg_reader #(.STABLE_CYCLES(N)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .A       (A),
    .B       (B),
    .C       (C),
    .D       (D),
    .E       (E),
    .F       (F),
    .G       (G),
    .Ack     (Ack),
    .X3      (X3),
    .X2      (X2),
    .X1      (X1),
    .X0      (X0),
    .Valid   (Valid),
    .Error   (Error)
`ifdef SEVEN_SEG_READER_ERRCNT_EN
    ,
    .ErrCount(ErrCount)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] x;
    logic       err;
  } vec_t;

  vec_t vecs [19];

  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic logic [3:0] xval();
    return {X3, X2, X1, X0};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_seg(input logic [6:0] v);
    {A, B, C, D, E, F, G} = v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      pass_cnt++;
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One reset edge, check the cleared outputs, then release with a pattern.
  task automatic do_reset(input logic [6:0] pat);
    Resetn = 1'b0;
    tick();
    check("reset valid", 32'(Valid), 32'd0);
    check("reset x", 32'(xval()), 32'd0);
    check("reset error", 32'(Error), 32'd0);
`ifdef SEVEN_SEG_READER_ERRCNT_EN
    check("reset errcount", 32'(ErrCount), 32'd0);
`endif
    set_seg(pat);
    Resetn = 1'b1;
  endtask

  // Count edges until Valid rises; 0 means it never rose within the bound.
  task automatic wait_valid(input int exp_edges, input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (Valid) begin
        n = i;
        break;
      end
    end
    check({name, " latency"}, 32'(n), 32'(exp_edges));
  endtask

  task automatic do_ack();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
  endtask

  initial begin
    int vcount;
    logic [3:0] lastx;

    vecs[0]  = '{7'b0000001, 4'h0, 1'b0};
    vecs[1]  = '{7'b1001111, 4'h1, 1'b0};
    vecs[2]  = '{7'b0010010, 4'h2, 1'b0};
    vecs[3]  = '{7'b0000110, 4'h3, 1'b0};
    vecs[4]  = '{7'b1001100, 4'h4, 1'b0};
    vecs[5]  = '{7'b0100100, 4'h5, 1'b0};
    vecs[6]  = '{7'b0100000, 4'h6, 1'b0};
    vecs[7]  = '{7'b0001111, 4'h7, 1'b0};
    vecs[8]  = '{7'b0000000, 4'h8, 1'b0};
    vecs[9]  = '{7'b0000100, 4'h9, 1'b0};
    vecs[10] = '{7'b0001000, 4'hA, 1'b0};
    vecs[11] = '{7'b1100000, 4'hB, 1'b0};
    vecs[12] = '{7'b0110001, 4'hC, 1'b0};
    vecs[13] = '{7'b1000010, 4'hD, 1'b0};
    vecs[14] = '{7'b0110000, 4'hE, 1'b0};
    vecs[15] = '{7'b0111000, 4'hF, 1'b0};
    vecs[16] = '{7'b1111110, 4'h0, 1'b1};
    vecs[17] = '{7'b1010101, 4'h0, 1'b1};
    vecs[18] = '{7'b1111111, 4'h0, 1'b1};

    Ack = 1'b0;
    Resetn = 1'b0;
    set_seg(7'b1111111);
    tick();

    // Table: every glyph once, in sequence, each acknowledged.
    do_reset(vecs[0].seg);
    for (int i = 0; i < 19; i++) begin
      if (i != 0) set_seg(vecs[i].seg);
      // From reset the first sample edge counts; from REARM one extra edge
      // is spent noticing the change.
      wait_valid((i == 0) ? N + 1 : N + 2, $sformatf("vec%0d", i));
      check($sformatf("vec%0d x", i), 32'(xval()), 32'(vecs[i].x));
      check($sformatf("vec%0d error", i), 32'(Error), 32'(vecs[i].err));
      do_ack();
      check($sformatf("vec%0d ack valid", i), 32'(Valid), 32'd0);
      check($sformatf("vec%0d ack error", i), 32'(Error), 32'd0);
      check($sformatf("vec%0d ack x kept", i), 32'(xval()), 32'(vecs[i].x));
    end
`ifdef SEVEN_SEG_READER_ERRCNT_EN
    check("errcount after table", 32'(ErrCount), 32'd3);
`endif

    // Same pattern after Ack is not reported again.
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Valid) vcount++;
    end
    check("rearm no repeat", 32'(vcount), 32'd0);

    // Hold 0100100 from edge 0: Valid after edge N, then stable in HOLD
    // while the inputs wander.
    do_reset(7'b0100100);
    wait_valid(N + 1, "digit5");
    check("digit5 x", 32'(xval()), 32'h5);
    check("digit5 error", 32'(Error), 32'd0);
    set_seg(7'b0000110);
    tick();
    set_seg(7'b1111110);
    tick();
    set_seg(7'b0111000);
    tick();
    check("hold valid kept", 32'(Valid), 32'd1);
    check("hold x kept", 32'(xval()), 32'h5);
    check("hold error kept", 32'(Error), 32'd0);

    // Reset for one cycle while in HOLD, same pattern present on release.
    set_seg(7'b0100100);
    do_reset(7'b0100100);
    wait_valid(N + 1, "reset in hold");
    check("reset in hold x", 32'(xval()), 32'h5);

    // Two cycles of 1001100, then 0000110: the count restarts at the change.
    do_reset(7'b1001100);
    vcount = 0;
    tick();
    if (Valid) vcount++;
    tick();
    if (Valid) vcount++;
    set_seg(7'b0000110);
    wait_valid(N + 1, "restart");
    check("restart early valid", 32'(vcount), 32'd0);
    check("restart x", 32'(xval()), 32'h3);

    // Illegal pattern 1111110.
    do_reset(7'b1111110);
    wait_valid(N + 1, "illegal");
    check("illegal x", 32'(xval()), 32'h0);
    check("illegal error", 32'(Error), 32'd1);
`ifdef SEVEN_SEG_READER_ERRCNT_EN
    check("illegal errcount", 32'(ErrCount), 32'd1);
    // 299 more illegal acceptances must saturate the count at 255.
    for (int i = 0; i < 299; i++) begin
      do_ack();
      set_seg((i % 2 == 0) ? 7'b1111101 : 7'b1111110);
      for (int k = 0; k < N + 6; k++) begin
        if (!Valid) tick();
      end
    end
    check("errcount saturated", 32'(ErrCount), 32'd255);
    check("errcount last error", 32'(Error), 32'd1);
`endif

    // Ack held high: one single-cycle Valid per accepted pattern.
    Resetn = 1'b0;
    Ack = 1'b1;
    tick();
    set_seg(7'b0110001);
    Resetn = 1'b1;
    vcount = 0;
    lastx = 4'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Valid) begin
        vcount++;
        lastx = xval();
      end
    end
    check("ack high C count", 32'(vcount), 32'd1);
    check("ack high C x", 32'(lastx), 32'hC);
    set_seg(7'b0111000);
    vcount = 0;
    lastx = 4'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Valid) begin
        vcount++;
        lastx = xval();
      end
    end
    check("ack high F count", 32'(vcount), 32'd1);
    check("ack high F x", 32'(lastx), 32'hF);
    Ack = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seven_seg_reader.md
SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, legal range 1..15: consecutive identical samples required to accept a pattern.
REQ-002 One clock; reset is synchronous and active-low; ports named Clock and Resetn.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Resetn  input  1  synchronous active-low reset.
REQ-005 A,B,C,D,E,F,G  input  1 each  active-low segment lines (0 = lit), bus order {A..G}.
REQ-006 Ack  input  1  consumer acknowledge of the held result.
REQ-007 X3,X2,X1,X0  output  1 each  decoded hex value, {X3..X0}.
REQ-008 Valid  output  1  result held on X3..X0/Error.
REQ-009 Error  output  1  held result came from an illegal pattern.

Function
REQ-010 {A..G} SHALL be registered into sample register S every cycle; all decisions use S only.
REQ-011 Legal map {A..G}->hex: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F; all other 112 patterns illegal.
REQ-012 Stability counter (4 bits) SHALL clear when S changes, else increment, saturating at STABLE_CYCLES.
REQ-013 FSM states: IDLE (counting), HOLD (Valid=1, awaiting Ack), REARM (awaiting pattern change).
REQ-014 IDLE->HOLD when counter reaches STABLE_CYCLES; latency: pattern constant from edge k first sampled at edge k, Valid high after edge k+STABLE_CYCLES.
REQ-015 On entering HOLD: legal pattern -> X=mapped value, Error=0; illegal -> X=0000, Error=1; accepted pattern stored as P.
REQ-016 In HOLD, X, Error, Valid SHALL stay constant regardless of segment inputs.
REQ-017 Ack sampled high in HOLD -> Valid, Error clear at that edge's output, X retains last value, state REARM; Ack outside HOLD ignored.
REQ-018 REARM->IDLE on first edge where S differs from P, counter cleared; identical pattern never reported twice consecutively.
REQ-019 Input change during IDLE counting SHALL restart the count; partial counts never produce Valid.
REQ-020 Ack high continuously SHALL cause Valid to be high for exactly one cycle per accepted pattern.

Reset
REQ-021 Resetn low at an edge: S=1111111 (all off), counter=0, P=1111111, X=0000, Valid=0, Error=0, state IDLE.
REQ-022 Reset mid-count or in HOLD/REARM SHALL discard the pending result; no Valid before STABLE_CYCLES+1 edges after release.

Configuration
REQ-023 Macro SEVEN_SEG_READER_ERRCNT_EN defined: extra output ErrCount, 8 bits, increments on each HOLD entry with Error=1, saturates at 255, cleared only by reset.
REQ-024 Macro undefined: ErrCount port and logic absent; all other behaviour identical.

Verification
REQ-025 STABLE_CYCLES=4, hold 0100100 from edge 0 -> Valid=1, X=0101, Error=0 after edge 4; stays until Ack.
REQ-026 Apply 1001100 for 2 cycles, then 0000110 held -> no Valid for 4; Valid with X=0011 after 4 more edges from the change.
REQ-027 Hold 1111110 (illegal) -> Valid=1, Error=1, X=0000; with macro defined ErrCount 0->1; repeat 300 illegal acceptances -> ErrCount=255.
REQ-028 Ack=1 constantly, pattern 0110001 held 20 cycles -> single 1-cycle Valid with X=1100; change to 0111000 -> second Valid with X=1111.
REQ-029 Resetn low one cycle while in HOLD -> Valid=0, X=0000 next cycle; same pattern still present -> Valid again after STABLE_CYCLES+1 edges.
